sram_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits as a slave port downstream of sram_xbar, in place of the lite UART model.
- The CPU writes bytes over the same sram-style interface that data_sram uses.
- Bytes are buffered in a TX FIFO and serialized 8N1, LSB first, on a single tx pin.
- A status word lets software poll for full, empty, busy and overflow.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/sram_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_sram_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART blocks.
// Contents: register byte offsets, STATUS word bit positions and the
// serializer state encoding.
package uart_pkg;

  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h8;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Ports: clk, rst (sync, active high), push/din write side, pop/dout read
// side (dout shows the head entry combinationally), full, empty, count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on an sram-style slave port.
// Ports: clk, rst (sync, active high); addra/dina/douta/ena/wea sram port
// (addra[3] selects TXDATA=0 / STATUS=1, douta registered); tx serial
// output (idles high); tx_busy high while the serializer is not IDLE.
//
// state | meaning
// IDLE  | line high, waiting for a FIFO entry
// START | start bit (low) for CLK_DIV cycles
// DATA  | eight data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (high); pops the next byte directly into START
module sram_uart_tx
  import uart_pkg::*;
#(
  parameter int LEN_ADDR   = 64,
  parameter int LEN_DATA   = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 868
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_ADDR-1:0]   addra,
  input  logic [LEN_DATA-1:0]   dina,
  output logic [LEN_DATA-1:0]   douta,
  input  logic                  ena,
  input  logic [LEN_DATA/8-1:0] wea,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  uart_tx_state_t state, state_nxt;
  logic [BW-1:0]  baud, baud_nxt;
  logic [2:0]     bit_idx, bit_nxt;
  logic [7:0]     shift, shift_nxt;
  logic           tx_nxt;
  logic           pop;
  logic           ovf;

  logic           full, empty;
  logic [CW-1:0]  count;
  logic [7:0]     fifo_dout;
  logic           wr_acc, push_req, ovf_set, ovf_clr;
  logic [LEN_DATA-1:0] status;
  logic           unused_bits;

  assign unused_bits = ^{addra[LEN_ADDR-1:4], addra[2:0], dina[LEN_DATA-1:8]};

  assign wr_acc   = ena && (wea != '0);
  assign push_req = ena && wea[0] && !addra[3];
  assign ovf_clr  = ena && wea[0] && addra[3] && dina[ST_OVF];
  // A pop in the same cycle frees the slot the push needs.
  assign ovf_set  = push_req && full && !pop;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (dina[7:0]),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          baud_nxt  = BAUD_MAX;
          state_nxt = START;
        end
      end
      START: begin
        if (baud == '0) begin
          baud_nxt  = BAUD_MAX;
          bit_nxt   = 3'd0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_nxt  = BAUD_MAX;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      STOP: begin
        if (baud == '0) begin
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            baud_nxt  = BAUD_MAX;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud - BW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx follows the current state one cycle late, so the falling edge lands
  // the cycle after the pop and every bit still lasts exactly CLK_DIV cycles.
  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign tx_busy = (state != IDLE);

  always_comb begin
    status = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = ovf;
    status[ST_CNT_MSB:ST_CNT_LSB] = (32'(count) > 32'd255) ? 8'hFF : 8'(count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      ovf     <= 1'b0;
      douta   <= '0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (ena) begin
        if (wr_acc)        douta <= '0;
        else if (addra[3]) douta <= status;
        else               douta <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_uart_tx.sv
module tb_sram_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] addra = '0;
  logic [63:0] dina = '0;
  logic [63:0] douta;
  logic        ena = 1'b0;
  logic [7:0]  wea = '0;
  logic        tx;
  logic        tx_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sram_uart_tx #(
    .LEN_ADDR(64), .LEN_DATA(64), .FIFO_DEPTH(4), .CLK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .addra(addra), .dina(dina), .douta(douta),
    .ena(ena), .wea(wea), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Frame decoder: samples the middle of each 4-cycle bit.
  logic [7:0] frames[$];
  int         fstart[$];
  int         ferr = 0;
  bit         prev_tx = 1'b1;
  bit         in_frame = 1'b0;
  int         mcnt = 0;
  int         fs = 0;
  logic [7:0] mbyte = '0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (prev_tx && !tx) begin
        in_frame = 1'b1;
        mcnt = 0;
        fs = cyc;
      end
    end else begin
      mcnt++;
    end
    if (!rst && in_frame && (mcnt % 4 == 2)) begin
      if (mcnt / 4 == 0) begin
        if (tx !== 1'b0) ferr++;
      end else if (mcnt / 4 <= 8) begin
        mbyte[mcnt/4 - 1] = tx;
      end else begin
        if (tx !== 1'b1) ferr++;
        frames.push_back(mbyte);
        fstart.push_back(fs);
        in_frame = 1'b0;
      end
    end
    prev_tx = tx;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    ena = 1'b1; addra = a; dina = d; wea = 8'h01;
    @(negedge clk);
    ena = 1'b0; wea = '0;
  endtask

  task automatic rd_status(output logic [63:0] v);
    ena = 1'b1; addra = 64'h8; wea = '0;
    @(negedge clk);
    ena = 1'b0;
    v = douta;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (tx_busy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, {63'd0, tx_busy}, 64'd0);
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int i = 0;
    while (frames.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(frames.size()), 64'(n));
  endtask

  task automatic burst6(input logic [7:0] base);
    ena = 1'b1; addra = 64'h0; wea = 8'h01;
    for (int i = 0; i < 6; i++) begin
      dina = 64'(base + 8'(i));
      @(negedge clk);
    end
    ena = 1'b0; wea = '0;
  endtask

  initial begin
    logic [63:0] v;
    logic [7:0]  b55;
    int          busy_cnt;
    int          low_cnt;
    int          bidx;
    logic        exp_tx;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx", {63'd0, tx}, 64'd1);
    chk("rst_busy", {63'd0, tx_busy}, 64'd0);
    chk("rst_douta", douta, 64'd0);
    rd_status(v);
    chk("rst_status", v, 64'h2);

    // Single byte, cycle-exact waveform.
    b55 = 8'h55;
    busy_cnt = 0;
    wr(64'h0, 64'h55);
    chk("k0_tx", {63'd0, tx}, 64'd1);
    chk("k0_busy", {63'd0, tx_busy}, 64'd0);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      if (k < 2) exp_tx = 1'b1;
      else begin
        bidx = (k - 2) / 4;
        if (bidx == 0)      exp_tx = 1'b0;
        else if (bidx <= 8) exp_tx = b55[bidx-1];
        else                exp_tx = 1'b1;
      end
      chk($sformatf("tx55_k%0d", k), {63'd0, tx}, {63'd0, exp_tx});
    end
    chk("busy_len", 64'(busy_cnt), 64'd40);
    chk("busy_end", {63'd0, tx_busy}, 64'd0);
    chk("f55_val", {56'd0, frames[0]}, 64'h55);

    // Three back-to-back bytes.
    wait_idle("idle1");
    frames.delete(); fstart.delete();
    ena = 1'b1; addra = 64'h0; wea = 8'h01;
    dina = 64'h01; @(negedge clk);
    dina = 64'h02; @(negedge clk);
    dina = 64'h03; @(negedge clk);
    addra = 64'h8; wea = '0; @(negedge clk);
    ena = 1'b0;
    chk("b2b_status", douta, 64'h204);
    wait_frames("b2b_frames", 3, 200);
    if (frames.size() == 3) begin
      chk("b2b_f0", {56'd0, frames[0]}, 64'h01);
      chk("b2b_f1", {56'd0, frames[1]}, 64'h02);
      chk("b2b_f2", {56'd0, frames[2]}, 64'h03);
      chk("b2b_gap01", 64'(fstart[1] - fstart[0]), 64'd40);
      chk("b2b_gap12", 64'(fstart[2] - fstart[1]), 64'd40);
    end

    // Overflow: six writes into a four-entry FIFO.
    wait_idle("idle2");
    frames.delete(); fstart.delete();
    burst6(8'hA0);
    rd_status(v);
    chk("ovf_status", v, 64'h40D);
    wait_frames("ovf_frames", 5, 400);
    repeat (60) @(negedge clk);
    chk("ovf_nframes", 64'(frames.size()), 64'd5);
    if (frames.size() >= 5) begin
      chk("ovf_f0", {56'd0, frames[0]}, 64'hA0);
      chk("ovf_f4", {56'd0, frames[4]}, 64'hA4);
    end
    wait_idle("idle3");
    rd_status(v);
    chk("ovf_sticky", v, 64'h0A);
    wr(64'h8, 64'h8);
    chk("wr_douta0", douta, 64'd0);
    rd_status(v);
    chk("ovf_cleared", v, 64'h02);
    burst6(8'hB0);
    rd_status(v);
    chk("ovf_reset_again", v, 64'h40D);
    wait_idle("idle4");
    chk("frame_errs", 64'(ferr), 64'd0);

    // Reset during data bit 3 of 0x07 (bit 3 is 0, bit 2 is 1).
    frames.delete(); fstart.delete();
    wr(64'h0, 64'h07);
    wr(64'h0, 64'h08);
    repeat (18) @(negedge clk);
    chk("pre_rst_tx", {63'd0, tx}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx", {63'd0, tx}, 64'd1);
    chk("mid_rst_busy", {63'd0, tx_busy}, 64'd0);
    rd_status(v);
    chk("mid_rst_status", v, 64'h2);
    low_cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    chk("post_rst_low", 64'(low_cnt), 64'd0);
    chk("post_rst_frames", 64'(frames.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
